waveform_monitor: RTL and testbench

Receive-side measurement block for the 8-bit signed sample stream produced by the waveform generator top (data byte plus single-cycle valid strobe). On request it captures exactly one period of the incoming waveform, bounded by rising zero crossings. It reports minimum, maximum, peak-to-peak and period in samples, with a one-cycle result strobe. It sits on the bench/consumer side of the generator output and is used for on-chip self-check and loopback of the generator.

---
 rtl/waveform_monitor.sv | 178 +++++++++++++++++
 tb/tb_waveform_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_monitor.sv
// waveform_monitor
//   Measures one period of an 8-bit signed sample stream between two rising
//   zero crossings. It reports min, max, peak-to-peak and the period in
//   samples, together with a one-cycle result strobe.
//
// Ports
//   clk_i                  clock
//   rst_i                  asynchronous active-high reset
//   data_i [7:0]           signed sample
//   data_valid_strobe_i    qualifies data_i for one cycle
//   start_strobe_i         begin / restart a measurement (any state)
//   busy_o                 measurement in progress (ARMED or MEASURE)
//   result_valid_strobe_o  one-cycle pulse when the result outputs update
//   min_o [7:0]            signed minimum over the measured period
//   max_o [7:0]            signed maximum over the measured period
//   p2p_o [8:0]            unsigned max_o - min_o
//   period_o               period in samples, all-ones on timeout
//   timeout_o              last result ended by counter saturation
module waveform_monitor #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              data_i,
  input  logic                    data_valid_strobe_i,
  input  logic                    start_strobe_i,
  output logic                    busy_o,
  output logic                    result_valid_strobe_o,
  output logic [7:0]              min_o,
  output logic [7:0]              max_o,
  output logic [8:0]              p2p_o,
  output logic [PERIOD_WIDTH-1:0] period_o,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] COUNT_MAX = {PERIOD_WIDTH{1'b1}};

  state_t state, state_next;

  logic signed [7:0]       sample;
  logic signed [7:0]       prev_sample;
  logic                    prev_valid;
  logic signed [7:0]       run_min;
  logic signed [7:0]       run_max;
  logic [PERIOD_WIDTH-1:0] counter;
  logic [8:0]              run_p2p;

  logic accept;
  logic crossing;
  logic saturated;
  logic finish;
  logic finish_timeout;

  assign sample = data_i;

  // A sample that arrives together with start belongs to the old measurement
  // and is dropped. Samples in IDLE are ignored.
  assign accept = data_valid_strobe_i && !start_strobe_i && (state != IDLE);

  // Rising crossing: previous accepted sample negative, current non-negative.
  assign crossing  = prev_valid && prev_sample[7] && !sample[7];
  assign saturated = (counter == COUNT_MAX);

  // Sign-extend both operands to 9 bits. run_max >= run_min whenever this
  // value is published, so the result always fits 0..255.
  assign run_p2p = {run_max[7], run_max} - {run_min[7], run_min};

  assign busy_o = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. Saturation takes priority over a crossing, so a
  // saturated counter always ends the measurement on the next sample.
  always_comb begin
    state_next     = state;
    finish         = 1'b0;
    finish_timeout = 1'b0;
    if (start_strobe_i) begin
      state_next = ARMED;
    end else if (accept) begin
      case (state)
        ARMED: begin
          if (saturated) begin
            state_next     = IDLE;
            finish         = 1'b1;
            finish_timeout = 1'b1;
          end else if (crossing) begin
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (saturated) begin
            state_next     = IDLE;
            finish         = 1'b1;
            finish_timeout = 1'b1;
          end else if (crossing) begin
            state_next = IDLE;
            finish     = 1'b1;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Running accumulators and published results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_sample           <= '0;
      prev_valid            <= 1'b0;
      run_min               <= '0;
      run_max               <= '0;
      counter               <= '0;
      result_valid_strobe_o <= 1'b0;
      min_o                 <= '0;
      max_o                 <= '0;
      p2p_o                 <= '0;
      period_o              <= '0;
      timeout_o             <= 1'b0;
    end else begin
      result_valid_strobe_o <= finish;
      if (start_strobe_i) begin
        prev_valid <= 1'b0;
        counter    <= '0;
        run_min    <= 8'sd127;
        run_max    <= -8'sd128;
      end else if (accept) begin
        prev_sample <= sample;
        prev_valid  <= 1'b1;
        if (finish) begin
          timeout_o <= finish_timeout;
          period_o  <= finish_timeout ? COUNT_MAX : counter + 1'b1;
          // No period was ever entered when timing out while still armed.
          if (state == ARMED) begin
            min_o <= '0;
            max_o <= '0;
            p2p_o <= '0;
          end else begin
            min_o <= run_min;
            max_o <= run_max;
            p2p_o <= run_p2p;
          end
        end else if ((state == ARMED) && crossing) begin
          // The crossing sample is the first sample of the measured period.
          counter <= '0;
          run_min <= sample;
          run_max <= sample;
        end else begin
          counter <= counter + 1'b1;
          if (state == MEASURE) begin
            if (sample < run_min) begin
              run_min <= sample;
            end
            if (sample > run_max) begin
              run_max <= sample;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_waveform_monitor.sv
// tb_waveform_monitor
//   Self-checking bench for waveform_monitor. A reference model keeps every
//   accepted sample since the last start in a queue. It locates rising
//   crossings by index, and derives the period, extremes and timeouts from
//   index distances over that queue.
module tb_waveform_monitor;

  localparam int PW  = 16;
  localparam int SAT = 65535;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [7:0]    data_i = '0;
  logic          data_valid_strobe_i = 1'b0;
  logic          start_strobe_i = 1'b0;
  logic          busy_o;
  logic          result_valid_strobe_o;
  logic [7:0]    min_o;
  logic [7:0]    max_o;
  logic [8:0]    p2p_o;
  logic [PW-1:0] period_o;
  logic          timeout_o;

  waveform_monitor #(.PERIOD_WIDTH(PW)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .data_i                (data_i),
    .data_valid_strobe_i   (data_valid_strobe_i),
    .start_strobe_i        (start_strobe_i),
    .busy_o                (busy_o),
    .result_valid_strobe_o (result_valid_strobe_o),
    .min_o                 (min_o),
    .max_o                 (max_o),
    .p2p_o                 (p2p_o),
    .period_o              (period_o),
    .timeout_o             (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int    check_count  = 0;
  int    err_count    = 0;
  int    strobe_count = 0;
  string phase        = "init";

  // reference model state
  bit            model_active = 1'b0;
  int            samp_q[$];
  int            arm_idx = -1;
  logic [7:0]    exp_min = '0;
  logic [7:0]    exp_max = '0;
  logic [8:0]    exp_p2p = '0;
  logic [PW-1:0] exp_period = '0;
  logic          exp_timeout = 1'b0;
  logic          exp_strobe = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput({phase, ".strobe"}, 32'(result_valid_strobe_o), 32'(exp_strobe));
    checkOutput({phase, ".busy"},   32'(busy_o),    32'(model_active));
    checkOutput({phase, ".min"},    32'(min_o),     32'(exp_min));
    checkOutput({phase, ".max"},    32'(max_o),     32'(exp_max));
    checkOutput({phase, ".p2p"},    32'(p2p_o),     32'(exp_p2p));
    checkOutput({phase, ".period"}, 32'(period_o),  32'(exp_period));
    checkOutput({phase, ".timeout"},32'(timeout_o), 32'(exp_timeout));
  endtask

  // Publish a result covering queue entries [lo, hi).
  task automatic publishSpan(input int lo, input int hi, input bit is_timeout);
    int mn = 127;
    int mx = -128;
    for (int i = lo; i < hi; i++) begin
      if (samp_q[i] < mn) mn = samp_q[i];
      if (samp_q[i] > mx) mx = samp_q[i];
    end
    exp_min      = 8'(mn);
    exp_max      = 8'(mx);
    exp_p2p      = 9'(mx - mn);
    exp_period   = is_timeout ? PW'(SAT) : PW'(hi - lo);
    exp_timeout  = is_timeout;
    exp_strobe   = 1'b1;
    model_active = 1'b0;
  endtask

  task automatic modelStep(input logic [7:0] d, input bit v, input bit s);
    int cur;
    int n;
    exp_strobe = 1'b0;
    if (s) begin
      model_active = 1'b1;
      samp_q.delete();
      arm_idx = -1;
    end else if (v && model_active) begin
      cur = int'($signed(d));
      samp_q.push_back(cur);
      n = samp_q.size() - 1;
      if (arm_idx < 0) begin
        // While armed, n samples have been counted before sample n arrives.
        if (n == SAT) begin
          exp_min      = '0;
          exp_max      = '0;
          exp_p2p      = '0;
          exp_period   = PW'(SAT);
          exp_timeout  = 1'b1;
          exp_strobe   = 1'b1;
          model_active = 1'b0;
        end else if (n >= 1 && samp_q[n-1] < 0 && cur >= 0) begin
          arm_idx = n;
        end
      end else begin
        if (n - arm_idx - 1 == SAT) begin
          publishSpan(arm_idx, n, 1'b1);
        end else if (samp_q[n-1] < 0 && cur >= 0) begin
          publishSpan(arm_idx, n, 1'b0);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, then check every output against the model.
  task automatic applyStimulus(input logic [7:0] d, input bit v, input bit s);
    data_i              = d;
    data_valid_strobe_i = v;
    start_strobe_i      = s;
    @(posedge clk_i);
    #1;
    modelStep(d, v, s);
    checkAll();
    if (result_valid_strobe_o) strobe_count++;
  endtask

  function automatic logic [7:0] squareSample(input int k, input int per,
                                              input int amp);
    return (k % per < per / 2) ? 8'(-amp) : 8'(amp);
  endfunction

  function automatic logic [7:0] sineSample(input int k);
    real x;
    real v;
    int  r;
    x = 2.0 * 3.14159265358979 * real'(k) / 64.0;
    v = 127.0 * $sin(x);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return 8'(r);
  endfunction

  task automatic modelReset();
    model_active = 1'b0;
    samp_q.delete();
    arm_idx     = -1;
    exp_min     = '0;
    exp_max     = '0;
    exp_p2p     = '0;
    exp_period  = '0;
    exp_timeout = 1'b0;
    exp_strobe  = 1'b0;
  endtask

  task automatic runSquare8();
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 24; k++) applyStimulus(squareSample(k, 8, 50), 1'b1, 1'b0);
  endtask

  initial begin
    int kind, per, hi, lo, vmax, k;
    logic [7:0] d;
    bit v, s;

    // power-on reset
    #1 rst_i = 1'b1;
    #1;
    phase = "reset0";
    modelReset();
    checkAll();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);

    // period-8 square, first crossing only arms
    phase = "square8";
    strobe_count = 0;
    runSquare8();
    checkOutput("square8.period_c", 32'(period_o), 32'd8);
    checkOutput("square8.min_c", 32'(min_o), 32'hCE);
    checkOutput("square8.max_c", 32'(max_o), 32'd50);
    checkOutput("square8.p2p_c", 32'(p2p_o), 32'd100);
    checkOutput("square8.timeout_c", 32'(timeout_o), 32'd0);
    checkOutput("square8.strobes", 32'(strobe_count), 32'd1);

    // full-scale sine, one valid every 4th cycle, junk on invalid cycles
    phase = "sine";
    strobe_count = 0;
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 140 * 4; i++) begin
      if (i % 4 == 0) applyStimulus(sineSample(i / 4), 1'b1, 1'b0);
      else applyStimulus(8'($urandom), 1'b0, 1'b0);
    end
    checkOutput("sine.period_c", 32'(period_o), 32'd64);
    checkOutput("sine.max_ge126", 32'($signed(max_o) >= 126), 32'd1);
    checkOutput("sine.min_le_m126", 32'($signed(min_o) <= -126), 32'd1);
    checkOutput("sine.p2p_ge252", 32'(p2p_o >= 9'd252), 32'd1);
    checkOutput("sine.strobes", 32'(strobe_count), 32'd1);

    // restart in MEASURE: period 8 +-50 replaced by period 12 +-30
    phase = "restart";
    strobe_count = 0;
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 7; j++) applyStimulus(squareSample(j, 8, 50), 1'b1, 1'b0);
    checkOutput("restart.busy_mid", 32'(busy_o), 32'd1);
    applyStimulus(squareSample(0, 12, 30), 1'b1, 1'b1);
    for (int j = 0; j < 40; j++) applyStimulus(squareSample(j, 12, 30), 1'b1, 1'b0);
    checkOutput("restart.strobes", 32'(strobe_count), 32'd1);
    checkOutput("restart.period_c", 32'(period_o), 32'd12);
    checkOutput("restart.p2p_c", 32'(p2p_o), 32'd60);

    // start coincides with -1, then 0: the 0 must not count as a crossing
    phase = "startdrop";
    strobe_count = 0;
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h05, 1'b1, 1'b0);
    checkOutput("startdrop.busy_c", 32'(busy_o), 32'd1);
    checkOutput("startdrop.strobes", 32'(strobe_count), 32'd0);

    // asynchronous reset during MEASURE, then a fresh measurement
    phase = "midreset";
    strobe_count = 0;
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 8; j++) applyStimulus(squareSample(j, 8, 50), 1'b1, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    checkOutput("midreset.strobes", 32'(strobe_count), 32'd0);
    phase = "postreset";
    runSquare8();
    checkOutput("postreset.period_c", 32'(period_o), 32'd8);
    checkOutput("postreset.p2p_c", 32'(p2p_o), 32'd100);

    // randomized waveforms with random gaps and random restarts
    for (int t = 0; t < 16; t++) begin
      phase = $sformatf("rand%0d", t);
      kind = $urandom_range(0, 2);
      per  = $urandom_range(2, 40);
      hi   = $urandom_range(1, 127);
      lo   = $urandom_range(1, 128);
      vmax = $urandom_range(1, 4);
      k    = 0;
      applyStimulus(8'($urandom), 1'($urandom), 1'b1);
      for (int i = 0; i < 300; i++) begin
        case (kind)
          0:       d = (k % per < per / 2) ? 8'(-lo) : 8'(hi);
          1:       d = 8'(-lo + ((hi + lo) * (k % per)) / (per - 1));
          default: d = 8'($urandom);
        endcase
        v = ($urandom_range(1, vmax) == 1);
        s = ($urandom_range(0, 199) == 0) ||
            (result_valid_strobe_o && ($urandom_range(0, 1) == 1));
        applyStimulus(d, v, s);
        if (v) k++;
      end
    end

    // constant +10 after start: counter saturates while still armed
    phase = "timeout";
    strobe_count = 0;
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < SAT + 3; i++) applyStimulus(8'd10, 1'b1, 1'b0);
    checkOutput("timeout.period_c", 32'(period_o), 32'hFFFF);
    checkOutput("timeout.flag_c", 32'(timeout_o), 32'd1);
    checkOutput("timeout.min_c", 32'(min_o), 32'd0);
    checkOutput("timeout.max_c", 32'(max_o), 32'd0);
    checkOutput("timeout.strobes", 32'(strobe_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
